// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   Receive-side FIFO between the UART receive shift engine and the system
//   bus read port. Characters are stored first-word-fall-through together
//   with a parity-error bit computed at write time. Occupancy, full and a
//   sticky overrun flag are tracked.
//
//   Optional feature macro: RX_PERR_CNT_EN adds an 8-bit saturating
//   parity-error counter (perr_cnt).
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   rx_com         one-cycle strobe, character received
//   data_received  {parity bit, data[DATA_W-1:0]}, sampled with rx_com
//   parity         00/11 none, 01 odd, 10 even
//   rd             one-cycle pop strobe, ignored when empty
//   clr_overrun    clears the sticky overrun flag
//   data_out       head-entry data (FWFT)
//   parity_error   head-entry parity status
//   flag           FIFO not empty
//   full           FIFO holds DEPTH entries
//   count          current occupancy
//   overrun        sticky, a character was dropped while full
//   perr_cnt       saturating parity-error count (RX_PERR_CNT_EN only)
module uart_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_com,
  input  logic [DATA_W:0]   data_received,
  input  logic [1:0]        parity,
  input  logic              rd,
  input  logic              clr_overrun,
  output logic [DATA_W-1:0] data_out,
  output logic              parity_error,
  output logic              flag,
  output logic              full,
  output logic [CNT_W-1:0]  count,
`ifdef RX_PERR_CNT_EN
  output logic [7:0]        perr_cnt,
`endif
  output logic              overrun
);

  logic [DATA_W:0]  mem_q [DEPTH];
  logic [DATA_W:0]  mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overrun_q, overrun_d;

  logic wr_en, rd_en, ovr_set, perr_calc, x_par;

  assign flag = (count_q != '0);
  assign full = (count_q == CNT_W'(DEPTH));

  // A full FIFO still accepts a write when a pop happens in the same cycle.
  assign rd_en   = rd & flag;
  assign wr_en   = rx_com & (~full | rd_en);
  assign ovr_set = rx_com & full & ~rd_en;

  assign x_par = ^data_received[DATA_W-1:0];

  always_comb begin
    perr_calc = 1'b0;
    case (parity)
      2'b01:   perr_calc = ~(x_par ^ data_received[DATA_W]);
      2'b10:   perr_calc = x_par ^ data_received[DATA_W];
      default: perr_calc = 1'b0;
    endcase
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = {perr_calc, data_received[DATA_W-1:0]};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
  end

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Set takes priority over clear when both happen in one cycle.
  always_comb begin
    overrun_d = overrun_q;
    if (ovr_set)          overrun_d = 1'b1;
    else if (clr_overrun) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out     = mem_q[rd_ptr_q][DATA_W-1:0];
  assign parity_error = mem_q[rd_ptr_q][DATA_W];
  assign count        = count_q;
  assign overrun      = overrun_q;

`ifdef RX_PERR_CNT_EN
  logic [7:0] perr_cnt_q, perr_cnt_d;

  // Only accepted writes count; dropped characters never reach storage.
  always_comb begin
    perr_cnt_d = perr_cnt_q;
    if (wr_en && perr_calc && (perr_cnt_q != 8'hFF)) perr_cnt_d = perr_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) perr_cnt_q <= 8'h00;
    else       perr_cnt_q <= perr_cnt_d;
  end

  assign perr_cnt = perr_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo_if.sv
module tb_uart_rx_fifo_if;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset;
  logic              rx_com;
  logic [DATA_W:0]   data_received;
  logic [1:0]        parity;
  logic              rd;
  logic              clr_overrun;
  logic [DATA_W-1:0] data_out;
  logic              parity_error;
  logic              flag;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overrun;
`ifdef RX_PERR_CNT_EN
  logic [7:0]        perr_cnt;
`endif

  uart_rx_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_com        (rx_com),
    .data_received (data_received),
    .parity        (parity),
    .rd            (rd),
    .clr_overrun   (clr_overrun),
    .data_out      (data_out),
    .parity_error  (parity_error),
    .flag          (flag),
    .full          (full),
    .count         (count),
`ifdef RX_PERR_CNT_EN
    .perr_cnt      (perr_cnt),
`endif
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rx;
    logic [8:0] din;
    logic [1:0] par;
    logic       rdv;
    logic       clr;
    logic       chk_data;
    logic [7:0] e_data;
    logic       e_perr;
    logic       e_flag;
    logic       e_full;
    int         e_count;
    logic       e_ovr;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rx, input logic [8:0] din, input logic [1:0] par,
                     input logic rdv, input logic clr, input logic chk,
                     input logic [7:0] e_data, input logic e_perr, input logic e_flag,
                     input logic e_full, input int e_count, input logic e_ovr);
    vec_t v;
    v.rx = rx; v.din = din; v.par = par; v.rdv = rdv; v.clr = clr;
    v.chk_data = chk; v.e_data = e_data; v.e_perr = e_perr; v.e_flag = e_flag;
    v.e_full = e_full; v.e_count = e_count; v.e_ovr = e_ovr;
    vecs.push_back(v);
  endtask

  // Called just after a rising edge; applies inputs for one cycle, then
  // returns 1 time unit after the next rising edge with inputs idle.
  task automatic step(input logic rx, input logic [8:0] din, input logic [1:0] par,
                      input logic rdv, input logic clr);
    rx_com = rx; data_received = din; parity = par; rd = rdv; clr_overrun = clr;
    @(posedge clk);
    #1;
    rx_com = 1'b0; rd = 1'b0; clr_overrun = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic e_flag, input logic e_full,
                              input int e_count, input logic e_ovr);
    check({tag, ".flag"},    32'(flag),    32'(e_flag));
    check({tag, ".full"},    32'(full),    32'(e_full));
    check({tag, ".count"},   32'(count),   32'(e_count));
    check({tag, ".overrun"}, 32'(overrun), 32'(e_ovr));
  endtask

  initial begin
    logic [7:0] w;
    reset = 1'b1; rx_com = 1'b0; data_received = '0; parity = 2'b00;
    rd = 1'b0; clr_overrun = 1'b0;

    // Fill, overrun, drain, clear overrun, pop on empty.
    add(1, 9'h011, 2'b00, 0, 0, 1, 8'h11, 0, 1, 0, 1, 0);
    add(1, 9'h022, 2'b00, 0, 0, 1, 8'h11, 0, 1, 0, 2, 0);
    add(1, 9'h033, 2'b00, 0, 0, 1, 8'h11, 0, 1, 0, 3, 0);
    add(1, 9'h044, 2'b00, 0, 0, 1, 8'h11, 0, 1, 1, 4, 0);
    add(1, 9'h055, 2'b00, 0, 0, 1, 8'h11, 0, 1, 1, 4, 1);
    add(0, 9'h000, 2'b00, 1, 0, 1, 8'h22, 0, 1, 0, 3, 1);
    add(0, 9'h000, 2'b00, 1, 0, 1, 8'h33, 0, 1, 0, 2, 1);
    add(0, 9'h000, 2'b00, 1, 0, 1, 8'h44, 0, 1, 0, 1, 1);
    add(0, 9'h000, 2'b00, 1, 0, 0, 8'h00, 0, 0, 0, 0, 1);
    add(0, 9'h000, 2'b00, 0, 1, 0, 8'h00, 0, 0, 0, 0, 0);
    add(0, 9'h000, 2'b00, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    // Parity: 0x07 has three ones. Odd mode with parity bit 1 gives an even
    // total (error); with parity bit 0 the total is odd (no error).
    add(1, 9'h107, 2'b01, 0, 0, 1, 8'h07, 1, 1, 0, 1, 0);
    add(1, 9'h007, 2'b01, 0, 0, 1, 8'h07, 1, 1, 0, 2, 0);
    add(1, 9'h003, 2'b10, 0, 0, 1, 8'h07, 1, 1, 0, 3, 0);
    add(1, 9'h1FE, 2'b11, 0, 0, 1, 8'h07, 1, 1, 1, 4, 0);
    add(0, 9'h000, 2'b00, 1, 0, 1, 8'h07, 0, 1, 0, 3, 0);
    add(0, 9'h000, 2'b00, 1, 0, 1, 8'h03, 0, 1, 0, 2, 0);
    add(0, 9'h000, 2'b00, 1, 0, 1, 8'hFE, 0, 1, 0, 1, 0);
    add(0, 9'h000, 2'b00, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    // Simultaneous write and read while full, then while empty.
    add(1, 9'h00A, 2'b00, 0, 0, 1, 8'h0A, 0, 1, 0, 1, 0);
    add(1, 9'h00B, 2'b00, 0, 0, 1, 8'h0A, 0, 1, 0, 2, 0);
    add(1, 9'h00C, 2'b00, 0, 0, 1, 8'h0A, 0, 1, 0, 3, 0);
    add(1, 9'h00D, 2'b00, 0, 0, 1, 8'h0A, 0, 1, 1, 4, 0);
    add(1, 9'h066, 2'b00, 1, 0, 1, 8'h0B, 0, 1, 1, 4, 0);
    add(0, 9'h000, 2'b00, 1, 0, 1, 8'h0C, 0, 1, 0, 3, 0);
    add(0, 9'h000, 2'b00, 1, 0, 1, 8'h0D, 0, 1, 0, 2, 0);
    add(0, 9'h000, 2'b00, 1, 0, 1, 8'h66, 0, 1, 0, 1, 0);
    add(0, 9'h000, 2'b00, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    add(1, 9'h077, 2'b00, 1, 0, 1, 8'h77, 0, 1, 0, 1, 0);
    add(0, 9'h000, 2'b00, 1, 0, 0, 8'h00, 0, 0, 0, 0, 0);
    // Overrun set wins over a simultaneous clear.
    add(1, 9'h001, 2'b00, 0, 0, 1, 8'h01, 0, 1, 0, 1, 0);
    add(1, 9'h002, 2'b00, 0, 0, 1, 8'h01, 0, 1, 0, 2, 0);
    add(1, 9'h003, 2'b00, 0, 0, 1, 8'h01, 0, 1, 0, 3, 0);
    add(1, 9'h004, 2'b00, 0, 0, 1, 8'h01, 0, 1, 1, 4, 0);
    add(1, 9'h005, 2'b00, 0, 1, 1, 8'h01, 0, 1, 1, 4, 1);
    add(0, 9'h000, 2'b00, 0, 1, 1, 8'h01, 0, 1, 1, 4, 0);

    #12;
    check("rst.data_out", 32'(data_out), 32'h0);
    check("rst.parity_error", 32'(parity_error), 32'h0);
    check_status("rst", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(vecs[i].rx, vecs[i].din, vecs[i].par, vecs[i].rdv, vecs[i].clr);
      if (vecs[i].chk_data) begin
        check({tag, ".data_out"},     32'(data_out),     32'(vecs[i].e_data));
        check({tag, ".parity_error"}, 32'(parity_error), 32'(vecs[i].e_perr));
      end
      check_status(tag, vecs[i].e_flag, vecs[i].e_full, vecs[i].e_count, vecs[i].e_ovr);
    end

`ifdef RX_PERR_CNT_EN
    check("perr_cnt", 32'(perr_cnt), 32'd1);
`endif

    // Drain the 4 entries left by the last table block.
    for (int i = 0; i < 4; i++) step(0, 9'h000, 2'b00, 1, 0);
    check_status("drain", 0, 0, 0, 0);

    // Wrap-around: pointers cross DEPTH-1 -> 0 several times.
    for (int i = 0; i < 10; i++) begin
      w = 8'($urandom_range(0, 255));
      step(1, {1'b0, w}, 2'b00, 0, 0);
      check($sformatf("wrap%0d.data_out", i), 32'(data_out), 32'(w));
      check($sformatf("wrap%0d.count_w", i), 32'(count), 32'd1);
      step(0, 9'h000, 2'b00, 1, 0);
      check($sformatf("wrap%0d.count_r", i), 32'(count), 32'd0);
    end

    // Reset mid-operation: 3 entries stored with overrun set.
    for (int i = 0; i < 5; i++) step(1, 9'(8'hA0 + i), 2'b00, 0, 0);
    step(0, 9'h000, 2'b00, 1, 0);
    check_status("pre_rst", 1, 0, 3, 1);
    check("pre_rst.data_out", 32'(data_out), 32'hA1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_status("mid_rst", 0, 0, 0, 0);
    check("mid_rst.data_out", 32'(data_out), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(1, 9'h05A, 2'b00, 0, 0);
    check("post_rst.data_out", 32'(data_out), 32'h5A);
    check_status("post_rst", 1, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
